// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a shared 4:1 TG mux: one-hot grants, binary select,
// per-grant bursts with valid/ready toward the consumer and a break-before-make gap.
module mux4_rr_sched #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned BUBBLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         grant_nxt;
    logic [1:0]         sel_nxt;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   beat_cnt_nxt;
    logic [CNT_W-1:0]   beat_inc;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_nxt;
    logic [1:0]         winner;
    logic [1:0]         scan_idx;
    logic               win_found;
    logic               cur_valid;
    logic               accept;

    // State register plus the grant/select/counter datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            sel      <= 2'b00;
            rr_ptr   <= 2'd3;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

    // Rotating priority scan starting just after the last winner
    always_comb begin
        winner    = rr_ptr;
        win_found = 1'b0;
        scan_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!win_found && req[scan_idx]) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    assign cur_valid = (state == XFER) && req[sel];
    assign accept    = cur_valid && out_ready;
    assign beat_inc  = beat_cnt + CNT_W'(1);

    // Next-state and datapath updates
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        sel_nxt      = sel;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        gap_cnt_nxt  = gap_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = XFER;
                    grant_nxt    = 4'b0001 << winner;
                    sel_nxt      = winner;
                    rr_ptr_nxt   = winner;
                    beat_cnt_nxt = '0;
                end
            end
            XFER: begin
                if (!req[sel]) begin
                    state_nxt   = GAP;
                    grant_nxt   = 4'b0000;
                    gap_cnt_nxt = '0;
                end else if (accept) begin
                    beat_cnt_nxt = beat_inc;
                    if (last[sel] || (beat_inc == CNT_W'(HOLD_MAX))) begin
                        state_nxt   = GAP;
                        grant_nxt   = 4'b0000;
                        gap_cnt_nxt = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(BUBBLE - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    // Handshake and status outputs follow the live request of the winner
    always_comb begin
        out_valid = cur_valid;
        busy      = (state == XFER);
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
Round-robin scheduler that shares the 4:1 transmission-gate multiplexer (mux4X1) among four requesters. It drives the mux select lines {s1,s0} and issues one-hot grants. Each grant covers a burst of beats on the shared output, which uses a valid/ready handshake toward the consumer. The block sits directly in front of mux4X1: `sel` connects to {s1,s0}, and the mux output `y` feeds the downstream consumer.

Parameters:
HOLD_MAX, 4, maximum accepted beats per grant before forced release; legal range 1..255.
BUBBLE, 1, idle cycles inserted between grants (break-before-make for the TG mux); legal range 1..3.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset; clears all state immediately, released synchronously by the integrator.
req  input  4  per-requester request; bit i asks for mux input i.
last  input  4  per-requester end-of-burst marker; qualified only on an accepted beat.
out_ready  input  1  downstream consumer ready.
grant  output  4  one-hot grant; all zero when not transferring.
sel  output  2  mux select {s1,s0} = binary index of the granted input.
out_valid  output  1  the muxed output carries a valid beat this cycle.
busy  output  1  high while in the XFER state.

Behaviour:
- States: IDLE, GAP, XFER.
- Reset values: state=IDLE; grant=4'b0000; sel=2'b00; beat_cnt=0; gap_cnt=0; rr_ptr=3 (requester 0 has highest priority after reset). Consequently out_valid=0 and busy=0.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, pick the first set req bit scanning rr_ptr+1, rr_ptr+2, ... modulo 4.
  - On the next edge: enter XFER, load grant and sel with the winner, set rr_ptr=winner, clear beat_cnt.
  - Grant latency: req high at edge N gives grant visible after edge N+1.
- XFER:
  - Combinational outputs: out_valid = req[g] (g = current winner); busy=1.
  - A beat is accepted when out_valid && out_ready; each accepted beat increments beat_cnt.
  - Release at the edge after any of:
    (a) an accepted beat with last[g]=1;
    (b) an accepted beat that brings beat_cnt to HOLD_MAX;
    (c) req[g]=0 while in XFER (requester withdrew; no beat is accepted).
  - On release: grant clears to 0 and state goes to GAP. sel is NOT changed.
  - out_ready=0 stalls the transfer: state, beat_cnt and sel hold indefinitely, and no timeout applies.
- GAP:
  - grant=0, out_valid=0, sel holds its previous value.
  - Lasts exactly BUBBLE cycles (gap_cnt), then returns to IDLE.
  - Arbitration happens only in IDLE, so minimum grant-to-grant spacing is BUBBLE+1 idle cycles.
- sel changes only on the IDLE->XFER transition. It never changes while grant is non-zero or during GAP.
- Fairness:
  - A requester holding req continuously is granted within 3 other grants.
  - The same requester may be regranted back-to-back only if no other req bit is set in IDLE.
- Requests from non-granted requesters are ignored in XFER/GAP. They are not latched, so a requester must hold req until granted.
- last is ignored on non-accepted cycles and for non-granted requesters.
- Reset mid-operation: grant and out_valid drop to 0 asynchronously; sel returns to 00; rr_ptr returns to 3. The partial burst is abandoned and not resumed.
- beat_cnt width: 8 bits; it never exceeds HOLD_MAX.
- grant is always one-hot or zero. sel always equals the index of the grant bit when grant is non-zero.

Test Plan:
- Reset then req=4'b0100, out_ready=1, last[2] on the 2nd beat -> grant=0100 and sel=10 one cycle after req; 2 beats accepted; grant=0 for 1 GAP cycle with sel held at 10; back to IDLE.
- req=4'b1111 held, last=4'b1111, out_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001; sel sequence 00, 01, 10, 11, 00; each grant is separated by GAP plus IDLE cycles.
- HOLD_MAX=4, req=4'b0011, last=0 -> requester 0 gets exactly 4 beats, then is forcibly released, and requester 1 is granted next.
- Requester 3 granted, out_ready held low for 10 cycles -> out_valid=1 throughout; beat_cnt, sel=11 and grant=1000 all stable; first accept occurs when out_ready rises.
- Requester 1 granted, req[1] dropped mid-burst with req[3]=1 -> out_valid=0 immediately; release to GAP at the next edge; requester 3 granted after GAP+IDLE.
- rst_n asserted low mid-XFER (async, between edges) -> grant=0 and out_valid=0 without a clock edge, sel=00; after release with req=4'b1001, requester 0 is granted first.
